// File: rtl/md_ctrl_if.sv
// md_ctrl_if: E-stage md instruction bus and HI/LO result bus for md_ctrl.
//   master drives md_op/start/flush/rs_val/rt_val/rd_sel/md_in_d and
//   observes busy/stall/hi/lo/rdata; slave is the controller side.
interface md_ctrl_if;
  logic [2:0]  md_op;
  logic        start;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_sel;
  logic        md_in_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  modport master(output md_op, start, flush, rs_val, rt_val, rd_sel, md_in_d,
                 input busy, stall, hi, lo, rdata);
  modport slave(input md_op, start, flush, rs_val, rt_val, rd_sel, md_in_d,
                output busy, stall, hi, lo, rdata);
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide sequencer with fixed-latency busy, D-stage stall and flush handling.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : md_ctrl_if.slave (op/start/flush/operands/read select in; busy/stall/hi/lo/rdata out)
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, nxt;
  logic [31:0] cnt, pend_hi, pend_lo, hi, lo;
  logic        div0, is_muldiv, is_div, accept, done, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] ua, ub, uq, ur, q, r;
  always_comb begin
    is_muldiv = bus.md_op >= 3'd1 && bus.md_op <= 3'd4;
    is_div    = bus.md_op == 3'd3 || bus.md_op == 3'd4;
    accept    = bus.start && !bus.flush && state == IDLE && bus.md_op >= 3'd1 && bus.md_op <= 3'd6;
    done      = state == BUSY && cnt == 32'd0;
    nxt       = (accept && is_muldiv) ? BUSY : done ? IDLE : state;
    prod      = bus.md_op == 3'd1 ? {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val}
                                  : {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    // Signed divide is done on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    a_neg     = bus.md_op == 3'd3 && bus.rs_val[31];
    b_neg     = bus.md_op == 3'd3 && bus.rt_val[31];
    ua        = a_neg ? -bus.rs_val : bus.rs_val;
    ub        = bus.rt_val == 32'd0 ? 32'd1 : b_neg ? -bus.rt_val : bus.rt_val;
    uq        = ua / ub;
    ur        = ua % ub;
    q         = (a_neg ^ b_neg) ? -uq : uq;
    r         = a_neg ? -ur : ur;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept && bus.md_op == 3'd5) begin
      hi <= bus.rs_val;
    end else if (accept && bus.md_op == 3'd6) begin
      lo <= bus.rs_val;
    end else if (accept && is_muldiv) begin
      pend_hi <= is_div ? r : prod[63:32];
      pend_lo <= is_div ? q : prod[31:0];
      div0    <= is_div && bus.rt_val == 32'd0;
      cnt     <= is_div ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
    end else if (state == BUSY) begin
      if (cnt != 32'd0) cnt <= cnt - 32'd1;
      else if (!div0) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end
  assign bus.busy  = state == BUSY;
  assign bus.stall = bus.md_in_d && (state == BUSY || (bus.start && !bus.flush && is_muldiv));
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.rdata = bus.rd_sel ? hi : lo;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: table-driven, scoreboarded bench for md_ctrl.
module tb_md_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  md_ctrl_if bus();
  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        fl;
    logic        stall;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;
  typedef struct {
    int          cyc;
    logic [31:0] hi, lo;
  } exp_t;

  vec_t tv[11];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total = 0;

  always @(posedge clk)
    if (reset) assert (!(bus.start && bus.busy)) else $error("start issued while busy");

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.rs_val = rs; bus.rt_val = rt; bus.flush = fl; bus.md_in_d = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.md_op = 3'd0; bus.flush = 1'b0;
  endtask

  // Counts busy cycles from the cycle after start; bounded so a stuck busy still ends.
  task automatic wait_done(input string name, input int already);
    int   cyc;
    logic stall_ok;
    exp_t e;
    cyc = already;
    stall_ok = 1'b1;
    while (bus.busy && cyc < 50) begin
      cyc++;
      if (!bus.stall) stall_ok = 1'b0;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk({name, " scoreboard"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({name, " busy_cycles"}, 64'(cyc), 64'(e.cyc));
    if (e.cyc > 0) chk({name, " stall_while_busy"}, 64'(stall_ok), 64'd1);
    chk({name, " hi"}, 64'(bus.hi), 64'(e.hi));
    chk({name, " lo"}, 64'(bus.lo), 64'(e.lo));
  endtask

  initial begin
    tv[0]  = '{3'd5, 32'h0000_0011, 32'd0, 1'b0, 1'b0, 0,  32'h0000_0011, 32'h0};
    tv[1]  = '{3'd6, 32'h0000_0022, 32'd0, 1'b0, 1'b0, 0,  32'h0000_0011, 32'h0000_0022};
    tv[2]  = '{3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tv[3]  = '{3'd4, 32'd7,         32'd2, 1'b0, 1'b1, 10, 32'd1,         32'd3};
    tv[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 10, 32'd0, 32'h8000_0000};
    tv[6]  = '{3'd5, 32'h0000_0011, 32'd0, 1'b0, 1'b0, 0,  32'h0000_0011, 32'h8000_0000};
    tv[7]  = '{3'd6, 32'h0000_0022, 32'd0, 1'b0, 1'b0, 0,  32'h0000_0011, 32'h0000_0022};
    tv[8]  = '{3'd3, 32'd9,         32'd0, 1'b0, 1'b1, 10, 32'h0000_0011, 32'h0000_0022};
    tv[9]  = '{3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 0,  32'hDEAD_BEEF, 32'h0000_0022};
    tv[10] = '{3'd1, 32'd2,         32'd3, 1'b1, 1'b0, 0,  32'hDEAD_BEEF, 32'h0000_0022};
    bus.md_op = 3'd0; bus.start = 1'b0; bus.flush = 1'b0; bus.rs_val = '0; bus.rt_val = '0;
    bus.rd_sel = 1'b0; bus.md_in_d = 1'b1;
    #12;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].op, tv[i].rs, tv[i].rt, tv[i].fl);
      sb.push_back('{tv[i].cyc, tv[i].hi, tv[i].lo});
      #1 chk($sformatf("vec%0d start_stall", i), 64'(bus.stall), 64'(tv[i].stall));
      @(negedge clk);
      idle_inputs();
      wait_done($sformatf("vec%0d", i), 0);
    end

    bus.rd_sel = 1'b1;
    #1 chk("rdata hi", 64'(bus.rdata), 64'hDEAD_BEEF);
    bus.rd_sel = 1'b0;
    #1 chk("rdata lo", 64'(bus.rdata), 64'h0000_0022);

    // flush during busy cycle 2 of a multu must not cancel the commit
    drive(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    sb.push_back('{5, 32'd1, 32'hFFFF_FFFE});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_done("flush_busy", 2);

    // reset on busy cycle 4 of a div aborts with no later commit
    drive(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("pre_reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("midop_reset busy", 64'(bus.busy), 64'd0);
    chk("midop_reset hi", 64'(bus.hi), 64'd0);
    chk("midop_reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_commit hi", 64'(bus.hi), 64'd0);
    chk("no_commit lo", 64'(bus.lo), 64'd0);
    drive(3'd1, 32'd4, 32'd4, 1'b0);
    sb.push_back('{5, 32'd0, 32'd16});
    @(negedge clk);
    idle_inputs();
    wait_done("post_reset_mult", 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
